// File: rtl/mult_ctrl_pkg.sv
// Shared constants, controller state encoding and the round-robin pick used
// by the multiplier-sharing arbiter.
package mult_ctrl_pkg;

   localparam int NREQ = 4;
   localparam int OPW  = 4;
   localparam int IDW  = 2;
   localparam int ZW   = 2 * OPW;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;

   typedef struct packed {
      logic           hit;
      logic [IDW-1:0] idx;
   } rr_sel_t;

   // Lowest offset from ptr wins, so scan the offsets from the far end down.
   function automatic rr_sel_t rr_select(input logic [NREQ-1:0] vld,
                                         input logic [IDW-1:0]  ptr);
      rr_sel_t        sel;
      logic [IDW-1:0] k;
      sel.hit = 1'b0;
      sel.idx = '0;
      for (int n = NREQ - 1; n >= 0; n--) begin
         k = ptr + IDW'(n);
         if (vld[k]) begin
            sel.hit = 1'b1;
            sel.idx = k;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/mult_share_arb_if.sv
// Requester and response handshake bundle between the requesters/consumer
// (master) and the multiplier-sharing arbiter (slave).
interface mult_share_arb_if;
   import mult_ctrl_pkg::*;

   logic [NREQ-1:0]     req_valid;
   logic [NREQ*OPW-1:0] req_a;
   logic [NREQ*OPW-1:0] req_b;
   logic [NREQ-1:0]     req_ready;
   logic                rsp_valid;
   logic [IDW-1:0]      rsp_id;
   logic [ZW-1:0]       rsp_z;
   logic                rsp_ready;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_z
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_z
   );

endinterface

// File: rtl/array_mult.sv
// Existing combinational unsigned array multiplier: sum of shifted partial
// products, one row per multiplier bit.
module array_mult
   import mult_ctrl_pkg::*;
(
   input  logic [OPW-1:0] op_a,
   input  logic [OPW-1:0] op_b,
   output logic [ZW-1:0]  z
);

   logic [ZW-1:0] w_acc;

   always_comb begin
      w_acc = '0;
      for (int i = 0; i < OPW; i++) begin
         if (op_b[i]) begin
            w_acc = w_acc + (ZW'(op_a) << i);
         end
      end
   end

   assign z = w_acc;

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin share of one array_mult among NREQ requesters. Operands and
// product are both registered so the array never touches an external path.
module mult_share_arb
   import mult_ctrl_pkg::*;
#(
   parameter int CNTW = 16
)(
   input  logic            clk,
   input  logic            rst_n,
   mult_share_arb_if.slave bus,
   output logic            busy,
   output logic [CNTW-1:0] done_count
);

   state_t          r_state;
   state_t          w_next;
   logic [IDW-1:0]  r_rr_ptr;
   logic [OPW-1:0]  r_op_a;
   logic [OPW-1:0]  r_op_b;
   logic [IDW-1:0]  r_id;
   logic            r_rsp_valid;
   logic [ZW-1:0]   r_rsp_z;
   logic [IDW-1:0]  r_rsp_id;
   logic [CNTW-1:0] r_done_count;
   rr_sel_t         w_sel;
   logic [NREQ-1:0] w_req_ready;
   logic            w_accept;
   logic [ZW-1:0]   w_z;

   assign w_sel = rr_select(bus.req_valid, r_rr_ptr);

   always_comb begin
      w_next      = r_state;
      w_req_ready = '0;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_sel.hit && rst_n) begin
               w_req_ready = NREQ'(1) << w_sel.idx;
               w_accept    = 1'b1;
               w_next      = CALC;
            end
         end
         CALC: w_next = HOLD;
         HOLD: begin
            if (bus.rsp_ready) begin
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= IDLE;
         r_rr_ptr     <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_z      <= '0;
         r_rsp_id     <= '0;
         r_done_count <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_rr_ptr <= w_sel.idx + IDW'(1);
         end
         if (r_state == CALC) begin
            r_rsp_z     <= w_z;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
         end
         if (r_state == HOLD && bus.rsp_ready) begin
            r_rsp_valid  <= 1'b0;
            r_done_count <= r_done_count + CNTW'(1);
         end
      end
   end

   // Operand capture is pure datapath; a reset mid-flight just leaves it stale.
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_op_a <= bus.req_a[w_sel.idx*OPW +: OPW];
         r_op_b <= bus.req_b[w_sel.idx*OPW +: OPW];
         r_id   <= w_sel.idx;
      end
   end

   array_mult u_array_mult (
      .op_a (r_op_a),
      .op_b (r_op_b),
      .z    (w_z)
   );

   assign bus.req_ready = w_req_ready;
   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_z     = r_rsp_z;
   assign bus.rsp_id    = r_rsp_id;
   assign busy          = (r_state != IDLE);
   assign done_count    = r_done_count;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb: reset, single request, contention,
// pointer wrap, backpressure, reset in CALC and request withdrawal.
module tb_mult_share_arb;
   import mult_ctrl_pkg::*;

   localparam int CNTW = 16;

   logic            clk;
   logic            rst_n;
   logic            busy;
   logic [CNTW-1:0] done_count;
   int              n_checks;
   int              n_fail;
   int              cyc;
   int              gcyc;
   int              last_g;
   int              d0;

   mult_share_arb_if bus();

   mult_share_arb #(.CNTW(CNTW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .busy       (busy),
      .done_count (done_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input int a, input int b);
      bus.req_a[i*OPW +: OPW] = OPW'(a);
      bus.req_b[i*OPW +: OPW] = OPW'(b);
   endtask

   // Waits (bounded) for a grant, checks it is exp_id, then takes the accept edge.
   task automatic wait_grant(input int exp_id, output int g_cyc);
      int n;
      n = 0;
      #1;
      while (bus.req_ready == '0 && n < 8) begin
         tick();
         n++;
      end
      check("grant", 32'(bus.req_ready), 32'(1) << exp_id);
      g_cyc = cyc;
      tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      bus.req_valid = '0;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b1;

      // Reset values and req_ready forced low under reset.
      rst_n = 1'b0;
      tick();
      tick();
      bus.req_valid = 4'b1111;
      #1;
      check("rst_req_ready", 32'(bus.req_ready), 0);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 0);
      check("rst_rsp_z", 32'(bus.rsp_z), 0);
      check("rst_rsp_id", 32'(bus.rsp_id), 0);
      check("rst_done", 32'(done_count), 0);
      check("rst_busy", 32'(busy), 0);
      bus.req_valid = '0;
      rst_n = 1'b1;
      tick();

      // Single request 3*5.
      set_op(0, 3, 5);
      bus.req_valid = 4'b0001;
      wait_grant(0, gcyc);
      bus.req_valid = '0;
      check("single_calc_busy", 32'(busy), 1);
      check("single_calc_vld", 32'(bus.rsp_valid), 0);
      tick();
      check("single_vld", 32'(bus.rsp_valid), 1);
      check("single_z", 32'(bus.rsp_z), 15);
      check("single_id", 32'(bus.rsp_id), 0);
      tick();
      check("single_done", 32'(done_count), 1);
      check("single_vld_low", 32'(bus.rsp_valid), 0);

      // Full contention: a_i = i+1, b_i = 2, grants 0,1,2,3,0 three cycles apart.
      do_reset();
      for (int i = 0; i < 4; i++) set_op(i, i + 1, 2);
      bus.req_valid = 4'b1111;
      last_g = 0;
      for (int k = 0; k < 5; k++) begin
         wait_grant(k % 4, gcyc);
         if (k > 0) check("cont_gap", 32'(gcyc - last_g), 3);
         last_g = gcyc;
         tick();
         check("cont_vld", 32'(bus.rsp_valid), 1);
         check("cont_z", 32'(bus.rsp_z), 32'(2 * ((k % 4) + 1)));
         check("cont_id", 32'(bus.rsp_id), 32'(k % 4));
         tick();
      end

      // Pointer wrap: grant 2 to land the pointer on 3, then 1001 gives 3 then 0.
      do_reset();
      bus.req_valid = 4'b0100;
      wait_grant(2, gcyc);
      tick();
      check("wrap2_z", 32'(bus.rsp_z), 6);
      tick();
      bus.req_valid = 4'b1001;
      wait_grant(3, gcyc);
      tick();
      check("wrap3_z", 32'(bus.rsp_z), 8);
      check("wrap3_id", 32'(bus.rsp_id), 3);
      tick();
      wait_grant(0, gcyc);
      tick();
      check("wrap0_z", 32'(bus.rsp_z), 2);
      check("wrap0_id", 32'(bus.rsp_id), 0);
      tick();

      // Backpressure in HOLD with 15*15 (pointer is 1 here).
      bus.req_valid = 4'b0010;
      bus.rsp_ready = 1'b0;
      set_op(1, 15, 15);
      d0 = int'(done_count);
      wait_grant(1, gcyc);
      bus.req_valid = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
         #1;
         check("bp_vld", 32'(bus.rsp_valid), 1);
         check("bp_z", 32'(bus.rsp_z), 225);
         check("bp_req_ready", 32'(bus.req_ready), 0);
         check("bp_done", 32'(done_count), 32'(d0));
         tick();
      end
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      #1;
      check("bp_done_pre", 32'(done_count), 32'(d0));
      tick();
      check("bp_done_post", 32'(done_count), 32'(d0 + 1));
      check("bp_vld_low", 32'(bus.rsp_valid), 0);

      // Reset while in CALC (pointer is 2, so requester 0 wins by wrap).
      set_op(0, 1, 2);
      bus.req_valid = 4'b0001;
      wait_grant(0, gcyc);
      bus.req_valid = '0;
      check("rc_busy", 32'(busy), 1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("rc_vld", 32'(bus.rsp_valid), 0);
      check("rc_z", 32'(bus.rsp_z), 0);
      check("rc_id", 32'(bus.rsp_id), 0);
      check("rc_done", 32'(done_count), 0);
      check("rc_busy_low", 32'(busy), 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("rc_no_rsp", 32'(bus.rsp_valid), 0);
      end
      bus.req_valid = 4'b1111;
      wait_grant(0, gcyc);

      // Withdrawal: requester 1 pulses during HOLD; pointer is 1 but 3 wins.
      bus.req_valid = 4'b1000;
      set_op(3, 7, 3);
      bus.rsp_ready = 1'b0;
      tick();
      check("wd_z", 32'(bus.rsp_z), 2);
      bus.req_valid = 4'b1010;
      tick();
      check("wd_hold_vld", 32'(bus.rsp_valid), 1);
      bus.req_valid = 4'b1000;
      bus.rsp_ready = 1'b1;
      tick();
      wait_grant(3, gcyc);
      tick();
      check("wd_z3", 32'(bus.rsp_z), 21);
      check("wd_id3", 32'(bus.rsp_id), 3);
      bus.req_valid = '0;
      tick();
      check("wd_done", 32'(done_count), 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
